// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - states, opcode classes and datapath select encodings
package multicycle_control_fsm_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'd2;

  localparam logic [1:0] WB_SEL_ALUOUT = 2'd0;
  localparam logic [1:0] WB_SEL_MDR    = 2'd1;
  localparam logic [1:0] WB_SEL_PC     = 2'd2;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_A      = 2'd1;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd2;

  localparam logic [1:0] SRC_B_B    = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  typedef struct packed {
    logic arith_r;
    logic arith_i;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic ecall;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_control_fsm_opcode_class_decoder.sv
// rtl/multicycle_control_fsm_opcode_class_decoder.sv - IR opcode to one-hot instruction class
module opcode_class_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  // The whole SYSTEM opcode is treated as ECALL; funct fields are not visible here.
  always_comb begin
    op_class = '0;
    case (opcode)
      OPC_R:      op_class.arith_r = 1'b1;
      OPC_I:      op_class.arith_i = 1'b1;
      OPC_LOAD:   op_class.load    = 1'b1;
      OPC_STORE:  op_class.store   = 1'b1;
      OPC_BRANCH: op_class.branch  = 1'b1;
      OPC_JAL:    op_class.jal     = 1'b1;
      OPC_JALR:   op_class.jalr    = 1'b1;
      OPC_SYSTEM: op_class.ecall   = 1'b1;
      default:    op_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - IF/ID/EX/MEM/WB sequencer and retired-instruction counter
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             alu_bcond,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             is_halted,
  output logic [CNT_W-1:0] instr_count
);

  state_t    state, next_state;
  op_class_t cls;
  logic      ir_w, pc_w, mem_r, mem_w, reg_w, count_inc;

  opcode_class_decoder u_dec (
    .opcode   (opcode),
    .op_class (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IF;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (count_inc)
        instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    pc_source  = 1'b0;
    iord       = 1'b0;
    wb_sel     = WB_SEL_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_B;
    alu_op     = ALU_OP_ADD;
    is_halted  = 1'b0;
    case (state)
      S_IF: begin
        mem_r     = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_w       = 1'b1;
          pc_w       = 1'b1;
          next_state = S_ID;
        end
      end
      S_ID: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        if (cls.ecall)        next_state = S_HALT;
        else if (cls.illegal) next_state = S_IF;
        else                  next_state = S_EX;
      end
      S_EX: begin
        next_state = S_IF;
        if (cls.arith_r) begin
          alu_src_a  = SRC_A_A;
          alu_op     = ALU_OP_FUNCT;
          next_state = S_WB;
        end else if (cls.arith_i) begin
          alu_src_a  = SRC_A_A;
          alu_src_b  = SRC_B_IMM;
          alu_op     = ALU_OP_FUNCT;
          next_state = S_WB;
        end else if (cls.load || cls.store) begin
          alu_src_a  = SRC_A_A;
          alu_src_b  = SRC_B_IMM;
          next_state = S_MEM;
        end else if (cls.branch) begin
          alu_src_a = SRC_A_A;
          alu_op    = ALU_OP_BRANCH;
          pc_w      = alu_bcond;
          pc_source = 1'b1;
        end else if (cls.jal) begin
          // rd takes the pre-update PC because both writes share this edge
          pc_w      = 1'b1;
          pc_source = 1'b1;
          reg_w     = 1'b1;
          wb_sel    = WB_SEL_PC;
        end else if (cls.jalr) begin
          alu_src_a = SRC_A_A;
          alu_src_b = SRC_B_IMM;
          pc_w      = 1'b1;
          reg_w     = 1'b1;
          wb_sel    = WB_SEL_PC;
        end
      end
      S_MEM: begin
        iord  = 1'b1;
        mem_r = cls.load;
        mem_w = cls.store;
        if (mem_ready)
          next_state = cls.load ? S_WB : S_IF;
      end
      S_WB: begin
        reg_w      = 1'b1;
        wb_sel     = cls.load ? WB_SEL_MDR : WB_SEL_ALUOUT;
        next_state = S_IF;
      end
      S_HALT: is_halted = 1'b1;
      default: next_state = S_IF;
    endcase
  end

  assign count_inc = ((next_state == S_IF) && (state inside {S_ID, S_EX, S_MEM, S_WB})) ||
                     ((next_state == S_HALT) && (state != S_HALT));

  // Enables are gated directly by reset so nothing can fire before the state register settles.
  assign ir_write  = ir_w  & ~reset;
  assign pc_write  = pc_w  & ~reset;
  assign mem_read  = mem_r & ~reset;
  assign mem_write = mem_w & ~reset;
  assign reg_write = reg_w & ~reset;

endmodule
